// File: rtl/iomem_dma.sv
// Word-copy DMA engine for the PicoSoC iomem bus: a responder port holds the
// SRC/DST/COUNT/CTRL registers, an initiator port streams words from SRC to DST.
module iomem_dma #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] SRC_RESET = 32'h0,
  parameter logic [31:0] DST_RESET = 32'h0500_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP_R, S_WR, S_GAP_W} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, dst_q, cur_src_q, cur_dst_q, buf_q;
  // COUNT doubles as the remaining-word counter, so readback always shows what is left.
  logic [CNT_W-1:0] count_q;
  logic             src_inc_q, dst_inc_q, done_q, abort_q, zero_done_q;

  logic        busy, cfg_acc, cfg_wr, ctrl_wr;
  logic        start, done_clr, abort_req;
  logic        rd_hs, wr_hs, finish;
  logic [1:0]  sel;
  logic [31:0] rd_mux, count_ext, count_merged;
  logic        unused_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  st);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign busy      = (state_q != S_IDLE);
  assign sel       = iomem_addr[3:2];
  // Gating on !iomem_ready keeps ready a single-cycle pulse with a low cycle after it.
  assign cfg_acc   = iomem_valid && !iomem_ready;
  assign cfg_wr    = cfg_acc && (iomem_wstrb != 4'h0);
  assign ctrl_wr   = cfg_wr && (sel == 2'd3) && iomem_wstrb[0];
  assign start     = ctrl_wr && iomem_wdata[0] && !busy;
  assign done_clr  = ctrl_wr && iomem_wdata[1];
  assign abort_req = ctrl_wr && iomem_wdata[4] && busy;

  assign count_ext    = 32'(count_q);
  assign count_merged = merge_bytes(count_ext, iomem_wdata, iomem_wstrb);
  assign unused_bits  = ^{iomem_addr[31:4], iomem_addr[1:0], count_merged};

  always_comb begin
    case (sel)
      2'd0:    rd_mux = src_q;
      2'd1:    rd_mux = dst_q;
      2'd2:    rd_mux = count_ext;
      default: rd_mux = {28'h0, dst_inc_q, src_inc_q, done_q, busy};
    endcase
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    m_valid = 1'b0;
    m_wstrb = 4'h0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    rd_hs   = 1'b0;
    wr_hs   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: if (start && (count_q != '0)) state_d = S_RD;
      S_RD: begin
        m_valid = 1'b1;
        m_addr  = {cur_src_q[31:2], 2'b00};
        if (m_ready) begin
          rd_hs = 1'b1;
          // A pending abort drops the write that would follow this read.
          if (abort_q) begin
            state_d = S_IDLE;
            finish  = 1'b1;
          end else begin
            state_d = S_GAP_R;
          end
        end
      end
      S_GAP_R: begin
        if (abort_q) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        m_valid = 1'b1;
        m_wstrb = 4'hF;
        m_addr  = {cur_dst_q[31:2], 2'b00};
        m_wdata = buf_q;
        if (m_ready) begin
          wr_hs   = 1'b1;
          state_d = S_GAP_W;
        end
      end
      S_GAP_W: begin
        if ((count_q == '0) || abort_q) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end else begin
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state, including the data buffer, uses non-blocking assignments and is reset,
  // so an interrupted beat leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
      src_q       <= SRC_RESET;
      dst_q       <= DST_RESET;
      count_q     <= '0;
      cur_src_q   <= 32'h0;
      cur_dst_q   <= 32'h0;
      buf_q       <= 32'h0;
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iomem_ready <= cfg_acc;
      if (cfg_acc) iomem_rdata <= rd_mux;

      if (cfg_wr && !busy) begin
        case (sel)
          2'd0: src_q   <= merge_bytes(src_q, iomem_wdata, iomem_wstrb);
          2'd1: dst_q   <= merge_bytes(dst_q, iomem_wdata, iomem_wstrb);
          2'd2: count_q <= count_merged[CNT_W-1:0];
          default: begin
            if (iomem_wstrb[0]) begin
              src_inc_q <= iomem_wdata[2];
              dst_inc_q <= iomem_wdata[3];
            end
          end
        endcase
      end else if (wr_hs) begin
        count_q <= count_q - CNT_W'(1);
      end

      if (start) begin
        cur_src_q <= src_q;
        cur_dst_q <= dst_q;
      end else if (wr_hs) begin
        if (src_inc_q) cur_src_q <= cur_src_q + 32'd4;
        if (dst_inc_q) cur_dst_q <= cur_dst_q + 32'd4;
      end

      if (rd_hs) buf_q <= m_rdata;

      zero_done_q <= start && (count_q == '0);

      // Completion beats a simultaneous DONE_CLR.
      if (finish || zero_done_q)   done_q <= 1'b1;
      else if (start || done_clr)  done_q <= 1'b0;

      if (state_d == S_IDLE) abort_q <= 1'b0;
      else if (abort_req)    abort_q <= 1'b1;
    end
  end

  assign irq = done_q;

endmodule
